// File: rtl/main_fsm.sv
// Multicycle processor main control FSM (Moore).
// Sequences fetch, decode, execute and writeback for data-processing,
// memory, branch and undefined instruction classes. Every output is a
// decode of the current state register only, so there is no input-to-output
// combinational path.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (0 = asserted)
//   Op         in   instruction class (00 DP, 01 mem, 10 branch, 11 undef)
//   Funct      in   instruction Funct field (bit5 immediate, bit0 load)
//   IRWrite    out  instruction register load enable
//   AdrSrc     out  memory address select (0 PC, 1 ALU result reg)
//   ALUSrcA    out  ALU A select (0 register, 1 PC)
//   ALUSrcB    out  ALU B select (00 reg, 01 ExtImm, 10 constant 4)
//   ResultSrc  out  result select (00 ALUOut, 01 Data, 10 ALUResult)
//   ALUOp      out  1 = ALU decoder uses Funct, 0 = force ADD
//   NextPC     out  unconditional PC write request
//   RegW       out  register write request (before condition gating)
//   MemW       out  memory write request (before condition gating)
//   Branch     out  conditional PC write request
//   State      out  current state encoding
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic [3:0] State
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
  } ctrl_t;

  // Plain vector rather than the enum type so encodings 11-15 are representable.
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  ctrl_t              ctrl;

  // Only Funct[5] and Funct[0] steer the sequence.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STATE_W'(FETCH);
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; Op/Funct matter only when leaving DECODE or MEMADR.
  always_comb begin
    state_d = STATE_W'(FETCH);
    case (state_q)
      FETCH:    state_d = STATE_W'(DECODE);
      DECODE: begin
        case (Op)
          OP_MEM:  state_d = STATE_W'(MEMADR);
          OP_DP:   state_d = Funct[5] ? STATE_W'(EXECUTEI) : STATE_W'(EXECUTER);
          OP_BR:   state_d = STATE_W'(BRANCH);
          default: state_d = STATE_W'(UNKNOWN);
        endcase
      end
      MEMADR:   state_d = Funct[0] ? STATE_W'(MEMRD) : STATE_W'(MEMWR);
      MEMRD:    state_d = STATE_W'(MEMWB);
      EXECUTER: state_d = STATE_W'(ALUWB);
      EXECUTEI: state_d = STATE_W'(ALUWB);
      // MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN and illegal codes return to FETCH.
      default:  state_d = STATE_W'(FETCH);
    endcase
  end

  // Moore output decode; anything not named for a state stays 0.
  always_comb begin
    ctrl = '0;
    case (state_q)
      FETCH: begin
        ctrl.irwrite   = 1'b1;
        ctrl.nextpc    = 1'b1;
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURES;
      end
      DECODE: begin
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURES;
      end
      MEMADR: begin
        ctrl.alusrcb   = SRCB_IMM;
      end
      MEMRD: begin
        ctrl.adrsrc    = 1'b1;
        ctrl.resultsrc = RES_ALUOUT;
      end
      MEMWB: begin
        ctrl.resultsrc = RES_DATA;
        ctrl.regw      = 1'b1;
      end
      MEMWR: begin
        ctrl.adrsrc    = 1'b1;
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.memw      = 1'b1;
      end
      EXECUTER: begin
        ctrl.alusrcb   = SRCB_REG;
        ctrl.aluop     = 1'b1;
      end
      EXECUTEI: begin
        ctrl.alusrcb   = SRCB_IMM;
        ctrl.aluop     = 1'b1;
      end
      ALUWB: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.regw      = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrcb   = SRCB_IMM;
        ctrl.resultsrc = RES_ALURES;
        ctrl.branch    = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign IRWrite   = ctrl.irwrite;
  assign AdrSrc    = ctrl.adrsrc;
  assign ALUSrcA   = ctrl.alusrca;
  assign ALUSrcB   = ctrl.alusrcb;
  assign ResultSrc = ctrl.resultsrc;
  assign ALUOp     = ctrl.aluop;
  assign NextPC    = ctrl.nextpc;
  assign RegW      = ctrl.regw;
  assign MemW      = ctrl.memw;
  assign Branch    = ctrl.branch;
  assign State     = state_q;

  // Commit strobes are mutually exclusive and tied to their commit states.
  a_commit_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot0({RegW, MemW, Branch}));
  a_regw_state : assert property (@(posedge clk) disable iff (!reset)
    RegW |-> (state_q == STATE_W'(MEMWB) || state_q == STATE_W'(ALUWB)));
  a_memw_state : assert property (@(posedge clk) disable iff (!reset)
    MemW |-> (state_q == STATE_W'(MEMWR)));

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: expected state/control pairs are queued
// per instruction and compared each cycle at the falling clock edge.
module tb_main_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] State;

  typedef struct packed {
    logic [3:0]  st;
    logic [11:0] ctl;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fails  = 0;
  logic [1:0] cur_op;
  logic [5:0] cur_funct;

  main_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .State     (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector: {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch}
  function automatic logic [11:0] model_ctl(input logic [3:0] s);
    case (s)
      4'd0:    return 12'b1_0_1_10_10_0_1_0_0_0;
      4'd1:    return 12'b0_0_1_10_10_0_0_0_0_0;
      4'd2:    return 12'b0_0_0_01_00_0_0_0_0_0;
      4'd3:    return 12'b0_1_0_00_00_0_0_0_0_0;
      4'd4:    return 12'b0_0_0_00_01_0_0_1_0_0;
      4'd5:    return 12'b0_1_0_00_00_0_0_0_1_0;
      4'd6:    return 12'b0_0_0_00_00_1_0_0_0_0;
      4'd7:    return 12'b0_0_0_01_00_1_0_0_0_0;
      4'd8:    return 12'b0_0_0_00_00_0_0_1_0_0;
      4'd9:    return 12'b0_0_0_01_10_0_0_0_0_1;
      default: return 12'b0;
    endcase
  endfunction

  function automatic logic [11:0] dut_ctl();
    return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_state(input logic [3:0] s);
    exp_t e;
    e.st  = s;
    e.ctl = model_ctl(s);
    exp_q.push_back(e);
  endtask

  // Each pop is compared at the next falling edge; inputs are held only
  // where the FSM samples them and scrambled everywhere else.
  task automatic drain(input string name);
    exp_t e;
    int   step = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq($sformatf("%s.state[%0d]", name, step), 16'(State), 16'(e.st));
      check_eq($sformatf("%s.ctrl[%0d]", name, step), 16'(dut_ctl()), 16'(e.ctl));
      if (e.st == 4'd1 || e.st == 4'd2) begin
        Op    = cur_op;
        Funct = cur_funct;
      end else begin
        Op    = 2'($urandom);
        Funct = 6'($urandom);
      end
      step++;
    end
  endtask

  task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] funct);
    cur_op    = op;
    cur_funct = funct;
    push_state(4'd0);
    push_state(4'd1);
    case (op)
      2'b01: begin
        push_state(4'd2);
        if (funct[0]) begin
          push_state(4'd3);
          push_state(4'd4);
        end else begin
          push_state(4'd5);
        end
      end
      2'b00: begin
        push_state(funct[5] ? 4'd7 : 4'd6);
        push_state(4'd8);
      end
      2'b10:   push_state(4'd9);
      default: push_state(4'd10);
    endcase
    drain(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    Op    = 2'b00;
    Funct = 6'b0;
    cur_op    = 2'b00;
    cur_funct = 6'b0;

    // Held in reset across edges: FETCH outputs, state does not advance.
    repeat (2) begin
      @(negedge clk);
      check_eq("reset.state", 16'(State), 16'd0);
      check_eq("reset.ctrl", 16'(dut_ctl()), 16'(model_ctl(4'd0)));
    end
    @(posedge clk);
    #1 reset = 1'b1;

    run_instr("ldr",     2'b01, 6'b011001);
    run_instr("str",     2'b01, 6'b011000);
    run_instr("add_reg", 2'b00, 6'b001000);
    run_instr("add_imm", 2'b00, 6'b101000);
    run_instr("b",       2'b10, 6'b000000);
    run_instr("undef",   2'b11, 6'b111111);

    // Asynchronous reset pulse inside MEMRD abandons the load.
    cur_op    = 2'b01;
    cur_funct = 6'b011001;
    push_state(4'd0);
    push_state(4'd1);
    push_state(4'd2);
    push_state(4'd3);
    drain("ldr_abort");
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst.state", 16'(State), 16'd0);
    check_eq("async_rst.ctrl", 16'(dut_ctl()), 16'(model_ctl(4'd0)));
    #1 reset = 1'b1;
    push_state(4'd1);
    push_state(4'd2);
    push_state(4'd3);
    push_state(4'd4);
    drain("ldr_after_rst");

    // Illegal encoding forced from BRANCH: outputs 0, back to FETCH next edge.
    cur_op    = 2'b10;
    cur_funct = 6'b0;
    push_state(4'd0);
    push_state(4'd1);
    push_state(4'd9);
    drain("b_pre_force");
    force dut.state_q = 4'd13;
    #1;
    check_eq("illegal.state", 16'(State), 16'd13);
    check_eq("illegal.ctrl", 16'(dut_ctl()), 16'd0);
    release dut.state_q;

    run_instr("add_imm2", 2'b00, 6'b100100);
    run_instr("str2",     2'b01, 6'b100110);

    push_state(4'd0);
    drain("final_fetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
